// File: rtl/scrambler_64b66b_pkg.sv
// Shared constants for the x^58 + x^39 + 1 self-synchronous scrambler.
// Tap positions, state width, sync counter width and state seed.
package scrambler_64b66b_pkg;

  localparam int TAP0 = 39;
  localparam int TAP1 = 58;
  localparam int STATE_W = 58;
  localparam int SYNC_CNT_W = $clog2(STATE_W + 1);

  localparam logic [STATE_W-1:0] SEED = '1;

endpackage

// File: rtl/scrambler_64b66b_lane.sv
// One lane of the 64b/66b scrambler/descrambler: state, sync counter,
// datapath and output register.
// Ports: clk, reset, valid_i, flush_i, bypass_i, data_i[LEN] ->
//        valid_o, data_o[LEN] (registered), synced_o.
module scrambler_64b66b_lane
  import scrambler_64b66b_pkg::*;
#(
  parameter int LEN        = 64,
  parameter bit DESCRAMBLE = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           valid_i,
  input  logic           flush_i,
  input  logic           bypass_i,
  input  logic [LEN-1:0] data_i,
  output logic           valid_o,
  output logic [LEN-1:0] data_o,
  output logic           synced_o
);

  localparam int EXT_W = STATE_W + LEN;
  localparam logic [SYNC_CNT_W-1:0] CNT_MAX =
    SYNC_CNT_W'(STATE_W);

  logic [STATE_W-1:0]    state_q;
  logic [STATE_W-1:0]    state_cur;
  logic [STATE_W-1:0]    state_nxt;
  logic [SYNC_CNT_W-1:0] cnt_q;
  logic [SYNC_CNT_W-1:0] cnt_cur;
  logic [SYNC_CNT_W-1:0] cnt_nxt;
  logic [EXT_W-1:0]      ext;
  logic [LEN-1:0]        res;

  // Flush re-seeds before the coincident beat is processed.
  assign state_cur = flush_i ? SEED : state_q;
  assign cnt_cur   = flush_i ? '0 : cnt_q;

  // ext holds the stream oldest-first: ext[0..57] is the history
  // (ext[57] = most recent state bit), ext[58+i] is beat bit i.
  // Taps s[i-39] and s[i-58] land at ext[i+19] and ext[i].
  always_comb begin
    ext = '0;
    res = '0;
    state_nxt = '0;
    for (int k = 0; k < STATE_W; k++) begin
      ext[k] = state_cur[STATE_W-1-k];
    end
    for (int i = 0; i < LEN; i++) begin
      res[i] = data_i[i]
             ^ ext[i + STATE_W - TAP0]
             ^ ext[i + STATE_W - TAP1];
      ext[STATE_W + i] = (bypass_i || DESCRAMBLE)
                       ? data_i[i] : res[i];
    end
    // Most recent 58 stream bits, newest at index 0.
    for (int k = 0; k < STATE_W; k++) begin
      state_nxt[k] = ext[EXT_W-1-k];
    end
  end

  always_comb begin
    cnt_nxt = cnt_cur;
    if (int'(cnt_cur) + LEN >= STATE_W) begin
      cnt_nxt = CNT_MAX;
    end else begin
      cnt_nxt = cnt_cur + SYNC_CNT_W'(LEN);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED;
      cnt_q   <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        state_q <= state_nxt;
        cnt_q   <= cnt_nxt;
        data_o  <= bypass_i ? data_i : res;
      end else begin
        state_q <= state_cur;
        cnt_q   <= cnt_cur;
      end
    end
  end

  assign synced_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/scrambler_64b66b_lanes.sv
// Multi-lane 64b/66b self-synchronous scrambler/descrambler top.
// Ports: clk, reset, valid_i/flush_i[LANES], bypass_i,
//        data_i[LANES*LEN] -> valid_o, data_o, synced_o.
module scrambler_64b66b_lanes
  import scrambler_64b66b_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int LEN        = 64,
  parameter bit DESCRAMBLE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LANES-1:0]     valid_i,
  input  logic [LANES-1:0]     flush_i,
  input  logic                 bypass_i,
  input  logic [LANES*LEN-1:0] data_i,
  output logic [LANES-1:0]     valid_o,
  output logic [LANES*LEN-1:0] data_o,
  output logic [LANES-1:0]     synced_o
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    scrambler_64b66b_lane #(
      .LEN        (LEN),
      .DESCRAMBLE (DESCRAMBLE)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .valid_i  (valid_i[l]),
      .flush_i  (flush_i[l]),
      .bypass_i (bypass_i),
      .data_i   (data_i[l*LEN +: LEN]),
      .valid_o  (valid_o[l]),
      .data_o   (data_o[l*LEN +: LEN]),
      .synced_o (synced_o[l])
    );
  end

endmodule

// File: tb/tb_scrambler_64b66b_lanes.sv
// Bench: 4-lane scrambler looped into a 4-lane descrambler, plus a
// 1-lane LEN=16 descrambler for self-sync.
module tb_scrambler_64b66b_lanes;

  localparam logic [63:0] ZERO_SCR = 64'h03FF_FF80_0000_0000;

  typedef struct {
    int           due;
    logic [3:0]   v;
    logic [255:0] d;
    logic [3:0]   s;
  } tx_e_t;

  typedef struct {
    int          due;
    logic [63:0] d;
  } rx_e_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   tx_valid = '0;
  logic [3:0]   tx_flush = '0;
  logic         tx_bypass = 1'b0;
  logic [255:0] tx_data = '0;
  logic [3:0]   tx_valid_o;
  logic [255:0] tx_data_o;
  logic [3:0]   tx_synced;
  logic [3:0]   rx_flush = '0;
  logic         rx_bypass = 1'b0;
  logic [3:0]   rx_valid_o;
  logic [255:0] rx_data_o;
  logic [3:0]   rx_synced;
  logic [0:0]   s_valid = '0;
  logic [0:0]   s_flush = '0;
  logic         s_bypass = 1'b0;
  logic [15:0]  s_data = '0;
  logic [0:0]   s_valid_o;
  logic [15:0]  s_data_o;
  logic [0:0]   s_synced;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  tx_e_t       txq[$];
  rx_e_t       rxq[4][$];
  logic [57:0] m_h[4];
  int          m_c[4];
  logic [63:0] m_last[4];
  logic [3:0]  pend_fl = '0;
  logic        pend_byp = 1'b0;
  tx_e_t       mon_te;
  rx_e_t       mon_re;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scrambler_64b66b_lanes #(
    .LANES(4), .LEN(64), .DESCRAMBLE(1'b0)
  ) u_tx (
    .clk(clk), .reset(reset),
    .valid_i(tx_valid), .flush_i(tx_flush),
    .bypass_i(tx_bypass), .data_i(tx_data),
    .valid_o(tx_valid_o), .data_o(tx_data_o),
    .synced_o(tx_synced)
  );

  scrambler_64b66b_lanes #(
    .LANES(4), .LEN(64), .DESCRAMBLE(1'b1)
  ) u_rx (
    .clk(clk), .reset(reset),
    .valid_i(tx_valid_o), .flush_i(rx_flush),
    .bypass_i(rx_bypass), .data_i(tx_data_o),
    .valid_o(rx_valid_o), .data_o(rx_data_o),
    .synced_o(rx_synced)
  );

  scrambler_64b66b_lanes #(
    .LANES(1), .LEN(16), .DESCRAMBLE(1'b1)
  ) u_rx16 (
    .clk(clk), .reset(reset),
    .valid_i(s_valid), .flush_i(s_flush),
    .bypass_i(s_bypass), .data_i(s_data),
    .valid_o(s_valid_o), .data_o(s_data_o),
    .synced_o(s_synced)
  );

  // Drive one beat into the tx/rx pair and push expectations.
  // rx flush/bypass follow the beat one cycle later.
  task automatic beat(input logic [3:0] v,
                      input logic [3:0] fl,
                      input logic rst,
                      input logic rb,
                      input logic [255:0] d);
    tx_e_t te;
    rx_e_t re;
    logic [63:0] o;
    logic s;
    @(posedge clk);
    #1;
    reset = rst;
    tx_valid = v;
    tx_flush = fl;
    tx_data = d;
    te.v = rst ? 4'b0 : v;
    if (rst) begin
      rx_flush = '0;
      rx_bypass = 1'b0;
      pend_fl = '0;
      pend_byp = 1'b0;
      for (int l = 0; l < 4; l++) begin
        m_h[l] = '1;
        m_c[l] = 0;
        m_last[l] = '0;
        while (rxq[l].size() > 0 &&
               rxq[l][$].due > cyc)
          void'(rxq[l].pop_back());
      end
    end else begin
      rx_flush = pend_fl;
      rx_bypass = pend_byp;
      pend_fl = fl;
      pend_byp = rb;
      for (int l = 0; l < 4; l++) begin
        if (fl[l]) begin
          m_h[l] = '1;
          m_c[l] = 0;
        end
        if (v[l]) begin
          for (int i = 0; i < 64; i++) begin
            s = d[l*64+i] ^ m_h[l][38] ^ m_h[l][57];
            o[i] = s;
            m_h[l] = {m_h[l][56:0], s};
          end
          m_c[l] = (m_c[l] + 64 >= 58) ? 58 : m_c[l] + 64;
          m_last[l] = o;
          re.due = cyc + 2;
          re.d = rb ? o : d[l*64 +: 64];
          rxq[l].push_back(re);
        end
      end
    end
    te.due = cyc + 1;
    for (int l = 0; l < 4; l++) begin
      te.d[l*64 +: 64] = m_last[l];
      te.s[l] = (m_c[l] == 58);
    end
    txq.push_back(te);
  endtask

  // Scoreboard monitor on the falling edge.
  always @(negedge clk) begin
    while (txq.size() > 0 && txq[0].due == cyc) begin
      mon_te = txq.pop_front();
      n_chk++;
      if (tx_valid_o !== mon_te.v ||
          tx_data_o !== mon_te.d ||
          tx_synced !== mon_te.s) begin
        n_fail++;
        $display("FAIL tx_out cyc=%0d got v=%h s=%h d=%h exp v=%h s=%h d=%h",
                 cyc, tx_valid_o, tx_synced, tx_data_o,
                 mon_te.v, mon_te.s, mon_te.d);
      end
    end
    for (int l = 0; l < 4; l++) begin
      if (rxq[l].size() > 0 && rxq[l][0].due == cyc) begin
        mon_re = rxq[l].pop_front();
        n_chk++;
        if (rx_valid_o[l] !== 1'b1 ||
            rx_data_o[l*64 +: 64] !== mon_re.d) begin
          n_fail++;
          $display("FAIL rx_out lane%0d cyc=%0d got v=%b d=%h exp d=%h",
                   l, cyc, rx_valid_o[l],
                   rx_data_o[l*64 +: 64], mon_re.d);
        end
      end else if (rx_valid_o[l] === 1'b1) begin
        n_chk++;
        n_fail++;
        $display("FAIL rx_unexpected lane%0d cyc=%0d got valid=1 exp 0",
                 l, cyc);
      end
    end
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic test_reset;
    for (int i = 0; i < 3; i++) beat(4'hF, '0, 1'b1, 1'b0, rnd256());
    beat('0, '0, 1'b0, 1'b0, '0);
    n_chk++;
    if (tx_valid_o !== 4'h0 || tx_data_o !== '0 ||
        tx_synced !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_tx got v=%h s=%h d=%h exp 0",
               tx_valid_o, tx_synced, tx_data_o);
    end
    n_chk++;
    if (rx_valid_o !== 4'h0 || rx_data_o !== '0 ||
        rx_synced !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_rx got v=%h s=%h d=%h exp 0",
               rx_valid_o, rx_synced, rx_data_o);
    end
    n_chk++;
    if (s_valid_o !== 1'b0 || s_data_o !== '0 ||
        s_synced !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rx16 got v=%b s=%b d=%h exp 0",
               s_valid_o, s_synced, s_data_o);
    end
  endtask

  task automatic test_scramble_zero;
    beat(4'b0001, '0, 1'b0, 1'b0, '0);
    beat('0, '0, 1'b0, 1'b0, '0);
    n_chk++;
    if (tx_data_o[63:0] !== ZERO_SCR) begin
      n_fail++;
      $display("FAIL scramble_zero got %h exp %h",
               tx_data_o[63:0], ZERO_SCR);
    end
    n_chk++;
    if (tx_synced !== 4'b0001) begin
      n_fail++;
      $display("FAIL synced_one_beat got %b exp 0001", tx_synced);
    end
    beat('0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_loopback;
    for (int b = 0; b < 1000; b++) begin
      beat(4'($urandom_range(0, 15)), '0, 1'b0, 1'b0, rnd256());
    end
    for (int b = 0; b < 3; b++) beat('0, '0, 1'b0, 1'b0, '0);
    n_chk++;
    if (rx_synced !== 4'hF) begin
      n_fail++;
      $display("FAIL loopback_synced got %b exp 1111", rx_synced);
    end
  endtask

  task automatic test_flush;
    logic [255:0] d;
    logic [57:0]  h;
    logic [63:0]  e;
    logic         s;
    for (int b = 0; b < 5; b++) beat(4'hF, '0, 1'b0, 1'b0, rnd256());
    d = rnd256();
    h = '1;
    for (int i = 0; i < 64; i++) begin
      s = d[128+i] ^ h[38] ^ h[57];
      e[i] = s;
      h = {h[56:0], s};
    end
    beat(4'hF, 4'b0100, 1'b0, 1'b0, d);
    beat(4'hF, '0, 1'b0, 1'b0, rnd256());
    n_chk++;
    if (tx_data_o[128 +: 64] !== e) begin
      n_fail++;
      $display("FAIL flush_seed got %h exp %h",
               tx_data_o[128 +: 64], e);
    end
    n_chk++;
    if (tx_synced !== 4'hF) begin
      n_fail++;
      $display("FAIL flush_synced got %b exp 1111", tx_synced);
    end
    beat('0, 4'b0010, 1'b0, 1'b0, '0);
    beat('0, '0, 1'b0, 1'b0, '0);
    n_chk++;
    if (tx_synced !== 4'b1101) begin
      n_fail++;
      $display("FAIL flush_idle_synced got %b exp 1101", tx_synced);
    end
    for (int b = 0; b < 4; b++) beat(4'hF, '0, 1'b0, 1'b0, rnd256());
  endtask

  task automatic test_bypass;
    for (int b = 0; b < 4; b++) beat(4'hF, '0, 1'b0, 1'b0, rnd256());
    for (int b = 0; b < 3; b++) beat(4'hF, '0, 1'b0, 1'b1, rnd256());
    for (int b = 0; b < 6; b++) beat(4'hF, '0, 1'b0, 1'b0, rnd256());
    beat('0, '0, 1'b0, 1'b0, '0);
    beat('0, '0, 1'b0, 1'b0, '0);
    n_chk++;
    if (rx_synced !== 4'hF) begin
      n_fail++;
      $display("FAIL bypass_synced got %b exp 1111", rx_synced);
    end
  endtask

  task automatic test_reset_mid;
    for (int b = 0; b < 4; b++) beat(4'hF, '0, 1'b0, 1'b0, rnd256());
    beat(4'hF, '0, 1'b1, 1'b0, rnd256());
    beat(4'b0001, '0, 1'b0, 1'b0, '0);
    n_chk++;
    if (tx_valid_o !== 4'h0 || tx_data_o !== '0 ||
        tx_synced !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_mid_tx got v=%h s=%h d=%h exp 0",
               tx_valid_o, tx_synced, tx_data_o);
    end
    n_chk++;
    if (rx_valid_o !== 4'h0 || rx_synced !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_mid_rx got v=%h s=%h exp 0",
               rx_valid_o, rx_synced);
    end
    beat('0, '0, 1'b0, 1'b0, '0);
    n_chk++;
    if (tx_data_o[63:0] !== ZERO_SCR) begin
      n_fail++;
      $display("FAIL reset_mid_seed got %h exp %h",
               tx_data_o[63:0], ZERO_SCR);
    end
    for (int b = 0; b < 3; b++) beat('0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_self_sync;
    logic [57:0] h;
    logic [15:0] d;
    logic [15:0] sc;
    logic [15:0] e;
    logic        s;
    logic [15:0] q[$];
    h = 58'h0AB_CDEF_0123_4567;
    for (int b = 0; b < 8; b++) begin
      d = 16'($urandom);
      for (int i = 0; i < 16; i++) begin
        s = d[i] ^ h[38] ^ h[57];
        sc[i] = s;
        h = {h[56:0], s};
      end
      @(posedge clk);
      #1;
      s_valid = 1'b1;
      s_data = sc;
      q.push_back(d);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      e = q.pop_front();
      n_chk++;
      if (s_valid_o !== 1'b1 || s_synced !== (b >= 3)) begin
        n_fail++;
        $display("FAIL self_sync_flags beat%0d got v=%b s=%b exp v=1 s=%b",
                 b, s_valid_o, s_synced, b >= 3);
      end
      if (b == 3) begin
        n_chk++;
        if (s_data_o[15:10] !== e[15:10]) begin
          n_fail++;
          $display("FAIL self_sync_edge got %h exp %h",
                   s_data_o[15:10], e[15:10]);
        end
      end else if (b > 3) begin
        n_chk++;
        if (s_data_o !== e) begin
          n_fail++;
          $display("FAIL self_sync_data beat%0d got %h exp %h",
                   b, s_data_o, e);
        end
      end
    end
  endtask

  initial begin
    for (int l = 0; l < 4; l++) begin
      m_h[l] = '1;
      m_c[l] = 0;
      m_last[l] = '0;
    end
    test_reset();
    test_scramble_zero();
    test_loopback();
    test_flush();
    test_bypass();
    test_reset_mid();
    test_self_sync();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (txq.size() != 0 || rxq[0].size() != 0 ||
        rxq[1].size() != 0 || rxq[2].size() != 0 ||
        rxq[3].size() != 0) begin
      n_fail++;
      $display("FAIL drain got tx=%0d rx0=%0d rx1=%0d rx2=%0d rx3=%0d exp 0",
               txq.size(), rxq[0].size(), rxq[1].size(),
               rxq[2].size(), rxq[3].size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
